// File: rtl/axi_burst_master.sv
// AXI burst master: independent read and write burst engines that move data
// between AXI and a pair of DMA FIFOs under a 4-phase start/done handshake.
module axi_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  // read request side
  input  logic                  axi_master_read_start,
  output logic                  axi_master_read_done,
  input  logic [ADDR_WIDTH-1:0] axi_master_target_read_addr,
  input  logic [BURST_LEN-1:0]  axi_master_target_read_burst_len,
  output logic                  master2dma_afifo_wpush,
  output logic [DATA_WIDTH-1:0] master2dma_afifo_wdata,
  input  logic                  master2dma_afifo_wfull,
  // write request side
  input  logic                  axi_master_write_start,
  output logic                  axi_master_write_done,
  input  logic [ADDR_WIDTH-1:0] axi_master_target_write_addr,
  input  logic [BURST_LEN-1:0]  axi_master_target_write_burst_len,
  output logic                  dma2master_afifo_rpull,
  input  logic                  dma2master_afifo_rempty,
  input  logic [DATA_WIDTH-1:0] dma2master_afifo_rdata,
  // AXI read address / data
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [BURST_LEN-1:0]  m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // AXI write address / data / response
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [BURST_LEN-1:0]  m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} wr_state_t;

  rd_state_t             rd_state, rd_state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [BURST_LEN-1:0]  rd_len;
  logic [BURST_LEN-1:0]  rd_cnt;
  logic                  rd_beat;

  wr_state_t             wr_state, wr_state_next;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BURST_LEN-1:0]  wr_len;
  logic [BURST_LEN-1:0]  wr_cnt;
  logic                  wr_beat;

  // ---------------- read engine ----------------
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_state_next;
      // request parameters are captured only on the idle->addr edge
      if (rd_state == R_IDLE && rd_state_next == R_ADDR) begin
        rd_addr <= axi_master_target_read_addr;
        rd_len  <= axi_master_target_read_burst_len;
        rd_cnt  <= '0;
      end else if (rd_beat) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rd_state_next          = rd_state;
    rd_beat                = 1'b0;
    m_axi_araddr           = '0;
    m_axi_arlen            = '0;
    m_axi_arvalid          = 1'b0;
    m_axi_rready           = 1'b0;
    master2dma_afifo_wpush = 1'b0;
    master2dma_afifo_wdata = '0;
    axi_master_read_done   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (axi_master_read_start) rd_state_next = R_ADDR;
      end
      R_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = rd_addr;
        m_axi_arlen   = rd_len;
        if (m_axi_arready) rd_state_next = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = !master2dma_afifo_wfull;
        if (m_axi_rvalid && !master2dma_afifo_wfull) begin
          rd_beat                = 1'b1;
          master2dma_afifo_wpush = 1'b1;
          master2dma_afifo_wdata = m_axi_rdata;
          // equality compare so len=all-ones still yields 2**BURST_LEN beats
          if (rd_cnt == rd_len) rd_state_next = R_DONE;
        end
      end
      R_DONE: begin
        axi_master_read_done = 1'b1;
        if (!axi_master_read_start) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // ---------------- write engine ----------------
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_state <= W_IDLE;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
    end else begin
      wr_state <= wr_state_next;
      if (wr_state == W_IDLE && wr_state_next == W_ADDR) begin
        wr_addr <= axi_master_target_write_addr;
        wr_len  <= axi_master_target_write_burst_len;
        wr_cnt  <= '0;
      end else if (wr_beat) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    wr_state_next          = wr_state;
    wr_beat                = 1'b0;
    m_axi_awaddr           = '0;
    m_axi_awlen            = '0;
    m_axi_awvalid          = 1'b0;
    m_axi_wdata            = '0;
    m_axi_wlast            = 1'b0;
    m_axi_wvalid           = 1'b0;
    m_axi_bready           = 1'b0;
    dma2master_afifo_rpull = 1'b0;
    axi_master_write_done  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (axi_master_write_start) wr_state_next = W_ADDR;
      end
      W_ADDR: begin
        m_axi_awvalid = 1'b1;
        m_axi_awaddr  = wr_addr;
        m_axi_awlen   = wr_len;
        if (m_axi_awready) wr_state_next = W_DATA;
      end
      W_DATA: begin
        // FIFO is first-word-fall-through, so its head is valid write data
        m_axi_wvalid = !dma2master_afifo_rempty;
        m_axi_wdata  = dma2master_afifo_rdata;
        m_axi_wlast  = (wr_cnt == wr_len);
        if (!dma2master_afifo_rempty && m_axi_wready) begin
          wr_beat                = 1'b1;
          dma2master_afifo_rpull = 1'b1;
          if (wr_cnt == wr_len) wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) wr_state_next = W_DONE;
      end
      W_DONE: begin
        axi_master_write_done = 1'b1;
        if (!axi_master_write_start) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: cycle-level AXI slave and FIFO models,
// one task per scenario with hand-computed expectations.
module tb_axi_burst_master;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b1;
  logic        axi_master_read_start = 1'b0;
  logic        axi_master_read_done;
  logic [31:0] axi_master_target_read_addr = '0;
  logic [7:0]  axi_master_target_read_burst_len = '0;
  logic        master2dma_afifo_wpush;
  logic [31:0] master2dma_afifo_wdata;
  logic        master2dma_afifo_wfull = 1'b0;
  logic        axi_master_write_start = 1'b0;
  logic        axi_master_write_done;
  logic [31:0] axi_master_target_write_addr = '0;
  logic [7:0]  axi_master_target_write_burst_len = '0;
  logic        dma2master_afifo_rpull;
  logic        dma2master_afifo_rempty = 1'b1;
  logic [31:0] dma2master_afifo_rdata = '0;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .axi_master_read_start(axi_master_read_start), .axi_master_read_done(axi_master_read_done),
    .axi_master_target_read_addr(axi_master_target_read_addr),
    .axi_master_target_read_burst_len(axi_master_target_read_burst_len),
    .master2dma_afifo_wpush(master2dma_afifo_wpush), .master2dma_afifo_wdata(master2dma_afifo_wdata),
    .master2dma_afifo_wfull(master2dma_afifo_wfull),
    .axi_master_write_start(axi_master_write_start), .axi_master_write_done(axi_master_write_done),
    .axi_master_target_write_addr(axi_master_target_write_addr),
    .axi_master_target_write_burst_len(axi_master_target_write_burst_len),
    .dma2master_afifo_rpull(dma2master_afifo_rpull), .dma2master_afifo_rempty(dma2master_afifo_rempty),
    .dma2master_afifo_rdata(dma2master_afifo_rdata),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int fails = 0;

  // results recorded by run_traffic
  logic [31:0] rd_data[$];
  logic [31:0] wr_data[$];
  int rd_pushes, ar_count, rd_done_cyc, rd_last_push_cyc, rd_done_cycles, stall_seen;
  int wr_pulls, aw_count, wr_last_cnt, wr_last_idx, bready_wait, b_count, wr_done_cycles;
  int proto_err;
  bit rd_done_seen, rd_fin, wr_done_seen, wr_fin, timeout;
  logic [31:0] ar_addr_seen, aw_addr_seen;
  logic [7:0]  ar_len_seen, aw_len_seen;

  function automatic logic [8:0] ctrl_outputs();
    return {m_axi_arvalid, m_axi_rready, master2dma_afifo_wpush, m_axi_awvalid, m_axi_wvalid,
            dma2master_afifo_rpull, m_axi_bready, axi_master_read_done, axi_master_write_done};
  endfunction

  task automatic idle_inputs();
    axi_master_read_start = 1'b0;  axi_master_write_start = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; master2dma_afifo_wfull = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    dma2master_afifo_rempty = 1'b1; dma2master_afifo_rdata = '0;
  endtask

  // Plays requester, AXI slave and both FIFOs cycle by cycle; inputs change at
  // the falling edge and outputs are observed 1ns later.
  task automatic run_traffic(
    input bit do_rd, input logic [31:0] raddr, input logic [7:0] rlen, input logic [31:0] rbase,
    input int ar_delay, input int stall_beat, input int stall_cycles, input bit early_drop,
    input bit do_wr, input logic [31:0] waddr, input logic [7:0] wlen, input logic [31:0] wbase,
    input bit toggle_wready, input bit empty_gaps, input int b_delay, input int abort_pushes);
    int cyc, ar_wait, stall_left, b_wait;
    bit ar_done, ar_first, aw_done, aw_first, b_pend, b_new;
    rd_data.delete(); wr_data.delete();
    rd_pushes = 0; ar_count = 0; rd_done_cyc = -1; rd_last_push_cyc = -1; rd_done_cycles = 0;
    stall_seen = 0; wr_pulls = 0; aw_count = 0; wr_last_cnt = 0; wr_last_idx = -1;
    bready_wait = 0; b_count = 0; wr_done_cycles = 0; proto_err = 0;
    rd_done_seen = 0; rd_fin = 0; wr_done_seen = 0; wr_fin = 0; timeout = 0;
    ar_addr_seen = '0; aw_addr_seen = '0; ar_len_seen = '0; aw_len_seen = '0;
    cyc = 0; ar_wait = 0; stall_left = stall_cycles; b_wait = 0;
    ar_done = 0; ar_first = 1; aw_done = 0; aw_first = 1; b_pend = 0;
    @(negedge cpu_clk);
    forever begin
      // requester: later address/length changes must be ignored by the DUT
      axi_master_read_start  = do_rd && !rd_done_seen && !(early_drop && ar_done);
      axi_master_target_read_addr      = (cyc == 0) ? raddr : ~raddr;
      axi_master_target_read_burst_len = (cyc == 0) ? rlen : ~rlen;
      axi_master_write_start = do_wr && !wr_done_seen;
      axi_master_target_write_addr      = (cyc == 0) ? waddr : ~waddr;
      axi_master_target_write_burst_len = (cyc == 0) ? wlen : ~wlen;
      m_axi_arready = (ar_wait >= ar_delay);
      m_axi_rvalid  = ar_done && (rd_pushes <= int'(rlen));
      m_axi_rdata   = rbase + rd_pushes;
      master2dma_afifo_wfull = (stall_left > 0) && (rd_pushes == stall_beat);
      m_axi_awready = 1'b1;
      dma2master_afifo_rempty = (wr_pulls > int'(wlen)) || (empty_gaps && (cyc % 3 == 1));
      dma2master_afifo_rdata  = wbase + wr_pulls;
      m_axi_wready = toggle_wready ? ((cyc % 2) == 1) : 1'b1;
      m_axi_bvalid = b_pend && (b_wait >= b_delay);
      #1;
      // read channel observation
      if (m_axi_arvalid) begin
        if (ar_first) begin
          ar_addr_seen = m_axi_araddr; ar_len_seen = m_axi_arlen; ar_first = 0;
        end else if (m_axi_araddr !== ar_addr_seen || m_axi_arlen !== ar_len_seen) proto_err++;
        if (m_axi_arready) begin ar_count++; ar_done = 1; ar_first = 1; end
        else ar_wait++;
      end
      if (master2dma_afifo_wfull && m_axi_rready) proto_err++;
      if (master2dma_afifo_wpush) begin
        if (!(m_axi_rvalid && m_axi_rready)) proto_err++;
        rd_data.push_back(master2dma_afifo_wdata);
        rd_pushes++; rd_last_push_cyc = cyc;
      end else if (m_axi_rvalid && m_axi_rready) proto_err++;
      if (master2dma_afifo_wfull && m_axi_rvalid && !m_axi_rready && !master2dma_afifo_wpush)
        stall_seen++;
      if (master2dma_afifo_wfull) stall_left--;
      if (axi_master_read_done) begin
        if (!rd_done_seen) begin rd_done_seen = 1; rd_done_cyc = cyc; end
        rd_done_cycles++;
      end else if (rd_done_seen) rd_fin = 1;
      // write channel observation
      if (m_axi_awvalid) begin
        if (aw_first) begin
          aw_addr_seen = m_axi_awaddr; aw_len_seen = m_axi_awlen; aw_first = 0;
        end else if (m_axi_awaddr !== aw_addr_seen || m_axi_awlen !== aw_len_seen) proto_err++;
        if (m_axi_awready) begin aw_count++; aw_done = 1; aw_first = 1; end
      end
      if (m_axi_wvalid && dma2master_afifo_rempty) proto_err++;
      b_new = 0;
      if (dma2master_afifo_rpull) begin
        if (!(m_axi_wvalid && m_axi_wready)) proto_err++;
        wr_data.push_back(m_axi_wdata);
        if (m_axi_wlast) begin wr_last_cnt++; wr_last_idx = wr_pulls; b_pend = 1; b_new = 1; b_wait = 0; end
        wr_pulls++;
      end else if (m_axi_wvalid && m_axi_wready) proto_err++;
      if (m_axi_bready) begin
        if (!b_pend) proto_err++;
        else if (!m_axi_bvalid) bready_wait++;
        else begin b_pend = 0; b_count++; end
      end
      if (b_pend && !b_new) b_wait++;
      if (axi_master_write_done) begin
        if (!wr_done_seen) wr_done_seen = 1;
        wr_done_cycles++;
      end else if (wr_done_seen) wr_fin = 1;
      if (abort_pushes > 0 && rd_pushes >= abort_pushes) return;
      if ((!do_rd || rd_fin) && (!do_wr || wr_fin)) break;
      cyc++;
      if (cyc >= 2000) begin timeout = 1; break; end
      @(negedge cpu_clk);
    end
    idle_inputs();
    #1;
    $display("burst: rd pushes=%0d ar=%0d wr pulls=%0d aw=%0d cycles=%0d", rd_pushes, ar_count,
             wr_pulls, aw_count, cyc);
  endtask

  task automatic test_reset();
    #1 cpu_rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_outputs() !== 9'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0", ctrl_outputs());
    end
    checks++;
    if ({m_axi_araddr, m_axi_awaddr, m_axi_wdata, master2dma_afifo_wdata, m_axi_wlast} !== '0) begin
      fails++; $display("FAIL reset_data: araddr %h awaddr %h expected 0", m_axi_araddr, m_axi_awaddr);
    end
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_read_basic();
    int bad;
    run_traffic(1, 32'h1000, 8'd3, 32'hA0, 2, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL rd_basic_timeout: got %0d expected 0", timeout); end
    checks++; if (ar_count !== 1) begin fails++; $display("FAIL rd_basic_ar_count: got %0d expected 1", ar_count); end
    checks++; if (ar_addr_seen !== 32'h1000) begin fails++; $display("FAIL rd_basic_araddr: got %h expected 1000", ar_addr_seen); end
    checks++; if (ar_len_seen !== 8'd3) begin fails++; $display("FAIL rd_basic_arlen: got %0d expected 3", ar_len_seen); end
    checks++; if (rd_pushes !== 4) begin fails++; $display("FAIL rd_basic_pushes: got %0d expected 4", rd_pushes); end
    bad = 0;
    foreach (rd_data[i]) if (rd_data[i] !== 32'hA0 + i) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL rd_basic_data: %0d wrong words expected 0", bad); end
    checks++; if (rd_done_cyc !== rd_last_push_cyc + 1) begin
      fails++; $display("FAIL rd_basic_done_time: got cycle %0d expected %0d", rd_done_cyc, rd_last_push_cyc + 1);
    end
    checks++; if (rd_done_cycles !== 2 || rd_fin !== 1'b1) begin
      fails++; $display("FAIL rd_basic_done_hold: got %0d cycles fin=%0d expected 2 fin=1", rd_done_cycles, rd_fin);
    end
    checks++; if (proto_err !== 0) begin fails++; $display("FAIL rd_basic_protocol: got %0d errors expected 0", proto_err); end
    checks++; if (ctrl_outputs() !== 9'd0) begin fails++; $display("FAIL rd_basic_idle: got %b expected 0", ctrl_outputs()); end
  endtask

  task automatic test_read_stall();
    int bad;
    run_traffic(1, 32'h1000, 8'd3, 32'hA0, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (rd_pushes !== 4) begin fails++; $display("FAIL rd_stall_pushes: got %0d expected 4", rd_pushes); end
    bad = 0;
    foreach (rd_data[i]) if (rd_data[i] !== 32'hA0 + i) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL rd_stall_data: %0d wrong words expected 0", bad); end
    checks++; if (stall_seen !== 3) begin fails++; $display("FAIL rd_stall_cycles: got %0d expected 3", stall_seen); end
    checks++; if (proto_err !== 0 || timeout !== 1'b0) begin
      fails++; $display("FAIL rd_stall_protocol: got %0d errors timeout=%0d expected 0", proto_err, timeout);
    end
  endtask

  task automatic test_write_single();
    run_traffic(0, 0, 0, 0, 0, -1, 0, 0, 1, 32'h8000, 8'd0, 32'h55, 0, 0, 2, 0);
    checks++; if (aw_count !== 1 || aw_addr_seen !== 32'h8000 || aw_len_seen !== 8'd0) begin
      fails++; $display("FAIL wr_single_aw: got count %0d addr %h len %0d expected 1 8000 0", aw_count, aw_addr_seen, aw_len_seen);
    end
    checks++; if (wr_pulls !== 1) begin fails++; $display("FAIL wr_single_pulls: got %0d expected 1", wr_pulls); end
    checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'h55) begin
      fails++; $display("FAIL wr_single_wdata: got %0d words expected one 0x55", wr_data.size());
    end
    checks++; if (wr_last_cnt !== 1 || wr_last_idx !== 0) begin
      fails++; $display("FAIL wr_single_wlast: got count %0d idx %0d expected 1 0", wr_last_cnt, wr_last_idx);
    end
    checks++; if (bready_wait !== 2 || b_count !== 1) begin
      fails++; $display("FAIL wr_single_bresp: got wait %0d resp %0d expected 2 1", bready_wait, b_count);
    end
    checks++; if (wr_done_seen !== 1'b1 || wr_fin !== 1'b1 || proto_err !== 0 || timeout !== 1'b0) begin
      fails++; $display("FAIL wr_single_done: got seen %0d fin %0d err %0d expected 1 1 0", wr_done_seen, wr_fin, proto_err);
    end
  endtask

  task automatic test_concurrent();
    int bad_r, bad_w;
    run_traffic(1, 32'h2000, 8'd7, 32'hB0, 1, -1, 0, 0, 1, 32'h4000, 8'd7, 32'hC0, 1, 1, 1, 0);
    bad_r = 0; bad_w = 0;
    foreach (rd_data[i]) if (rd_data[i] !== 32'hB0 + i) bad_r++;
    foreach (wr_data[i]) if (wr_data[i] !== 32'hC0 + i) bad_w++;
    checks++; if (rd_pushes !== 8 || bad_r !== 0) begin
      fails++; $display("FAIL conc_read: got %0d pushes %0d bad expected 8 0", rd_pushes, bad_r);
    end
    checks++; if (wr_pulls !== 8 || bad_w !== 0) begin
      fails++; $display("FAIL conc_write: got %0d pulls %0d bad expected 8 0", wr_pulls, bad_w);
    end
    checks++; if (wr_last_cnt !== 1 || wr_last_idx !== 7) begin
      fails++; $display("FAIL conc_wlast: got count %0d idx %0d expected 1 7", wr_last_cnt, wr_last_idx);
    end
    checks++; if (ar_addr_seen !== 32'h2000 || aw_addr_seen !== 32'h4000 || aw_len_seen !== 8'd7) begin
      fails++; $display("FAIL conc_addr: got ar %h aw %h awlen %0d expected 2000 4000 7", ar_addr_seen, aw_addr_seen, aw_len_seen);
    end
    checks++; if (rd_fin !== 1'b1 || wr_fin !== 1'b1 || proto_err !== 0 || timeout !== 1'b0) begin
      fails++; $display("FAIL conc_done: got rd %0d wr %0d err %0d expected 1 1 0", rd_fin, wr_fin, proto_err);
    end
  endtask

  task automatic test_start_drop();
    run_traffic(1, 32'h5000, 8'd1, 32'hE0, 0, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (rd_pushes !== 2 || ar_count !== 1) begin
      fails++; $display("FAIL drop_pushes: got %0d pushes %0d ar expected 2 1", rd_pushes, ar_count);
    end
    checks++; if (rd_done_cycles !== 1 || rd_fin !== 1'b1) begin
      fails++; $display("FAIL drop_done: got %0d done cycles fin %0d expected 1 1", rd_done_cycles, rd_fin);
    end
  endtask

  task automatic test_long_burst();
    int bad;
    run_traffic(1, 32'h6000, 8'd255, 32'h100, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bad = 0;
    foreach (rd_data[i]) if (rd_data[i] !== 32'h100 + i) bad++;
    checks++; if (rd_pushes !== 256 || bad !== 0) begin
      fails++; $display("FAIL long_pushes: got %0d pushes %0d bad expected 256 0", rd_pushes, bad);
    end
    checks++; if (ar_len_seen !== 8'd255 || rd_fin !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL long_done: got arlen %0d fin %0d expected 255 1", ar_len_seen, rd_fin);
    end
  endtask

  task automatic test_reset_midburst();
    int bad;
    run_traffic(1, 32'h1000, 8'd3, 32'hA0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    @(posedge cpu_clk);
    #1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hA2; master2dma_afifo_wfull = 1'b0;
    #1;
    checks++; if (master2dma_afifo_wpush !== 1'b1 || master2dma_afifo_wdata !== 32'hA2) begin
      fails++; $display("FAIL rst_mid_pre: got push %0d data %h expected 1 a2", master2dma_afifo_wpush, master2dma_afifo_wdata);
    end
    cpu_rst_n = 1'b0;
    #1;
    checks++; if (ctrl_outputs() !== 9'd0 || master2dma_afifo_wdata !== 32'h0) begin
      fails++; $display("FAIL rst_mid_async: got %b data %h expected 0", ctrl_outputs(), master2dma_afifo_wdata);
    end
    idle_inputs();
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    run_traffic(1, 32'h3000, 8'd1, 32'hD0, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ar_count !== 1 || ar_addr_seen !== 32'h3000 || ar_len_seen !== 8'd1) begin
      fails++; $display("FAIL rst_mid_fresh_ar: got count %0d addr %h len %0d expected 1 3000 1", ar_count, ar_addr_seen, ar_len_seen);
    end
    bad = 0;
    foreach (rd_data[i]) if (rd_data[i] !== 32'hD0 + i) bad++;
    checks++; if (rd_pushes !== 2 || bad !== 0 || rd_fin !== 1'b1) begin
      fails++; $display("FAIL rst_mid_fresh_data: got %0d pushes %0d bad expected 2 0", rd_pushes, bad);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_stall();
    test_write_single();
    test_concurrent();
    test_start_drop();
    test_long_burst();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, AXI data and FIFO data width.
REQ-003 The block SHALL have parameter BURST_LEN, default 8, width of the burst-length field (beats minus 1).
REQ-004 The block SHALL have port cpu_clk  in  1  clock; it SHALL be the only clock.
REQ-005 The block SHALL have port cpu_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port axi_master_read_start  in  1  read request level, held by the requester.
REQ-007 The block SHALL have port axi_master_read_done  out  1  read burst complete (level).
REQ-008 The block SHALL have port axi_master_target_read_addr  in  ADDR_WIDTH  read burst start address.
REQ-009 The block SHALL have port axi_master_target_read_burst_len  in  BURST_LEN  read beats minus 1.
REQ-010 The block SHALL have port master2dma_afifo_wpush  out  1  push read beat into FIFO.
REQ-011 The block SHALL have port master2dma_afifo_wdata  out  DATA_WIDTH  pushed read data.
REQ-012 The block SHALL have port master2dma_afifo_wfull  in  1  read-data FIFO full.
REQ-013 The block SHALL have port axi_master_write_start  in  1  write request level, held by the requester.
REQ-014 The block SHALL have port axi_master_write_done  out  1  write burst complete (level).
REQ-015 The block SHALL have port axi_master_target_write_addr  in  ADDR_WIDTH  write burst start address.
REQ-016 The block SHALL have port axi_master_target_write_burst_len  in  BURST_LEN  write beats minus 1.
REQ-017 The block SHALL have port dma2master_afifo_rpull  out  1  pop write data from FIFO.
REQ-018 The block SHALL have port dma2master_afifo_rempty  in  1  write-data FIFO empty.
REQ-019 The block SHALL have port dma2master_afifo_rdata  in  DATA_WIDTH  FIFO head word (first-word-fall-through).
REQ-020 The block SHALL have ports m_axi_araddr out ADDR_WIDTH; m_axi_arlen out BURST_LEN; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-021 The block SHALL have ports m_axi_rdata in DATA_WIDTH; m_axi_rvalid in 1; m_axi_rready out 1.
REQ-022 The block SHALL have ports m_axi_awaddr out ADDR_WIDTH; m_axi_awlen out BURST_LEN; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-023 The block SHALL have ports m_axi_wdata out DATA_WIDTH; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-024 The block SHALL have ports m_axi_bvalid in 1; m_axi_bready out 1.

Function
REQ-025 Read FSM (R_IDLE, R_ADDR, R_DATA, R_DONE) and write FSM (W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE) SHALL run concurrently and independently.
REQ-026 R_IDLE->R_ADDR when read_start=1 and read_done=0; addr and len latched that edge; later input changes ignored until R_IDLE.
REQ-027 R_ADDR: arvalid=1 with latched araddr/arlen held stable until arready; R_ADDR->R_DATA on arvalid&arready.
REQ-028 R_DATA: rready=!wfull; beat accepted on rvalid&rready; same cycle wpush=1, wdata=m_axi_rdata; beat counter increments.
REQ-029 Read burst = len+1 beats; after beat with counter==len, R_DATA->R_DONE; counter compare is equality, no wrap (len=255 gives 256 beats).
REQ-030 R_DONE: read_done=1; R_DONE->R_IDLE only when read_start=0 (4-phase handshake, no retrigger while start held).
REQ-031 W_IDLE->W_ADDR on write_start=1 and write_done=0, latching addr/len; W_ADDR drives awvalid per REQ-027; ->W_DATA on awvalid&awready.
REQ-032 W_DATA: wvalid=!rempty, wdata=dma2master_afifo_rdata, wlast=(counter==len), rpull=wvalid&wready; after last beat ->W_RESP.
REQ-033 W_RESP: bready=1; ->W_DONE on bvalid; W_DONE: write_done=1, ->W_IDLE when write_start=0.
REQ-034 Start deasserted mid-burst SHALL NOT abort; the burst completes and done is asserted for at least one cycle.
REQ-035 All AXI control outputs, wpush and rpull SHALL be 0 outside their owning states.

Reset
REQ-036 cpu_rst_n=0 SHALL immediately force both FSMs to idle, counters and latches to 0, and every output to 0; any in-flight burst is abandoned.

Verification
REQ-037 Read len=3, addr 0x1000, arready after 2 cycles, rdata 0xA0..0xA3 back-to-back -> arlen=3, 4 pushes A0..A3 in order, read_done next cycle, low after start drops.
REQ-038 Same read with wfull=1 for 3 cycles at beat 2 -> rready=0 and no push those cycles; exactly 4 pushes, no loss or duplication.
REQ-039 Write len=0, FIFO holds 0x55 -> one beat wdata=0x55 wlast=1, one rpull, bready until bvalid, then write_done.
REQ-040 Concurrent read len=7 and write len=7, wready toggling, rempty gaps -> 8 pushes, 8 pulls, wlast on 8th beat only, both dones.
REQ-041 Reset asserted in R_DATA after 2 beats -> outputs 0 without a clock edge; next read_start issues a fresh AR with newly latched addr.
